// File: rtl/jam_cost_server.sv
// jam_cost_server: 8x8 worker/job cost table for the JAM engine, with read coverage and result latch.
// Optional feature macro COST_PARITY_EN: per-entry even-parity bit and sticky PERR flag.
module jam_cost_server (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLR,
    input  logic       LD_VALID,
    input  logic [6:0] LD_DATA,
    output logic       LD_READY,
    input  logic [2:0] W,
    input  logic [2:0] J,
    output logic [6:0] Cost,
    input  logic       Valid,
    input  logic [9:0] MinCost,
    input  logic [3:0] MatchCount,
    output logic [9:0] RES_MIN,
    output logic [3:0] RES_CNT,
    output logic [6:0] RD_COUNT,
    output logic       ALL_READ,
    output logic       DONE,
    output logic       PERR
);

    typedef enum logic [1:0] {StLoad, StServe, StDone} state_e;

`ifdef COST_PARITY_EN
    localparam int unsigned EntryW = 8;
`else
    localparam int unsigned EntryW = 7;
`endif

    // Table storage is intentionally not reset; a fresh load always rewrites all 64 entries.
    logic [EntryW-1:0] cost_mem [64];

    state_e      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [63:0] seen_q, seen_d;
    logic [6:0]  rd_count_q, rd_count_d;
    logic [6:0]  cost_q, cost_d;
    logic [9:0]  res_min_q, res_min_d;
    logic [3:0]  res_cnt_q, res_cnt_d;
    logic        done_q, done_d;
    logic        mem_we;
    logic [5:0]  rd_idx;
    logic [EntryW-1:0] rd_entry;
    logic [EntryW-1:0] wr_entry;

`ifdef COST_PARITY_EN
    logic perr_q, perr_d;
    assign wr_entry = {^LD_DATA, LD_DATA};
`else
    assign wr_entry = LD_DATA;
`endif

    assign rd_idx   = {W, J};
    assign rd_entry = cost_mem[rd_idx];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        seen_d     = seen_q;
        rd_count_d = rd_count_q;
        cost_d     = cost_q;
        res_min_d  = res_min_q;
        res_cnt_d  = res_cnt_q;
        done_d     = done_q;
        mem_we     = 1'b0;
`ifdef COST_PARITY_EN
        perr_d     = perr_q;
`endif
        if (CLR) begin
            // Restart wins over any load beat or result strobe in the same cycle.
            state_d    = StLoad;
            addr_d     = '0;
            seen_d     = '0;
            rd_count_d = '0;
            cost_d     = '0;
            done_d     = 1'b0;
`ifdef COST_PARITY_EN
            perr_d     = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StLoad: begin
                    cost_d = '0;
                    if (LD_VALID) begin
                        mem_we = 1'b1;
                        if (addr_q == 6'd63) begin
                            addr_d  = '0;
                            state_d = StServe;
                        end else begin
                            addr_d = addr_q + 6'd1;
                        end
                    end
                end
                StServe: begin
                    cost_d         = rd_entry[6:0];
                    seen_d[rd_idx] = 1'b1;
                    if (!seen_q[rd_idx] && (rd_count_q != 7'd64)) begin
                        rd_count_d = rd_count_q + 7'd1;
                    end
`ifdef COST_PARITY_EN
                    if (^rd_entry) begin
                        perr_d = 1'b1;
                    end
`endif
                    if (Valid) begin
                        res_min_d = MinCost;
                        res_cnt_d = MatchCount;
                        done_d    = 1'b1;
                        state_d   = StDone;
                    end
                end
                StDone: begin
                end
                default: state_d = StLoad;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StLoad;
            addr_q     <= '0;
            seen_q     <= '0;
            rd_count_q <= '0;
            cost_q     <= '0;
            res_min_q  <= '0;
            res_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            seen_q     <= seen_d;
            rd_count_q <= rd_count_d;
            cost_q     <= cost_d;
            res_min_q  <= res_min_d;
            res_cnt_q  <= res_cnt_d;
            done_q     <= done_d;
        end
    end

    // Gate writes with RST so beats presented while reset is held never land in the table.
    always_ff @(posedge CLK) begin
        if (RST && mem_we) begin
            cost_mem[addr_q] <= wr_entry;
        end
    end

`ifdef COST_PARITY_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

    assign LD_READY = (state_q == StLoad);
    assign Cost     = cost_q;
    assign RES_MIN  = res_min_q;
    assign RES_CNT  = res_cnt_q;
    assign RD_COUNT = rd_count_q;
    assign ALL_READ = (rd_count_q == 7'd64);
    assign DONE     = done_q;

endmodule

// File: doc/jam_cost_server.md
# jam_cost_server

Cost-table responder for the JAM job-assignment engine. Holds the 8×8 worker/job cost matrix, loaded once through a streaming load port, and answers the engine's (W, J) index requests with the matching 7-bit Cost. It also records read coverage and latches the engine's final MinCost/MatchCount when Valid fires, so a bench can check the result directly.

## Interface
- No parameters; matrix fixed at 8×8, 7-bit entries.
- CLK  in  1  clock; block logic on posedge
- RST  in  1  reset, asynchronous, active-low
- CLR  in  1  synchronous restart to LOAD; table contents retained, rewritten by the next load
- LD_VALID  in  1  load beat valid
- LD_DATA  in  7  load beat cost value, row-major (index = W*8+J)
- LD_READY  out  1  high in LOAD
- W  in  3  worker index from engine
- J  in  3  job index from engine
- Cost  out  7  registered cost for current {W,J}
- Valid  in  1  engine result strobe
- MinCost  in  10  engine result
- MatchCount  in  4  engine result
- RES_MIN  out  10  latched MinCost
- RES_CNT  out  4  latched MatchCount
- RD_COUNT  out  7  distinct table entries read, 0..64
- ALL_READ  out  1  RD_COUNT == 64
- DONE  out  1  result latched
- PERR  out  1  sticky parity error (see Configuration)

## Operation
- States: LOAD → SERVE → DONE. Reset enters LOAD.
- LOAD: LD_READY=1. Each posedge with LD_VALID=1 writes LD_DATA to table[addr] and increments the 6-bit addr. The beat at addr=63 moves to SERVE and clears addr. Cost is held at 0.
- SERVE: each posedge, Cost <= table[{W,J}] and seen[{W,J}] <= 1. RD_COUNT increments only on the first read of an entry; it saturates at 64. Repeat reads do not count.
- SERVE with Valid=1 on a posedge: RES_MIN <= MinCost, RES_CNT <= MatchCount, DONE <= 1, go to DONE.
- DONE: Cost, RES_*, RD_COUNT and seen are frozen. Valid and LD_VALID are ignored.
- CLR on any posedge: go to LOAD with addr=0, seen=0, RD_COUNT=0, DONE=0 and Cost=0. RES_* hold their values. PERR clears. CLR takes priority over LD_VALID and Valid in the same cycle.
- LD_VALID outside LOAD is ignored. Valid outside SERVE is ignored.
- Reset mid-load discards the partial load; addr restarts at 0.
- Reset values: LD_READY=1, Cost=0, RES_MIN=0, RES_CNT=0, RD_COUNT=0, ALL_READ=0, DONE=0, PERR=0, addr=0, seen=0. Table contents are not reset.

## Timing
- The engine changes W/J on negedge CLK and samples Cost on the next negedge.
- This block registers Cost on the intervening posedge, so Cost for the (W,J) presented after negedge n is valid at negedge n+1. Latency is half a cycle, with no wait states.
- The first SERVE read happens on the posedge after the addr=63 load beat.
- Load throughput is one beat per cycle; the full load takes 64 cycles with LD_VALID held high.
- DONE rises on the posedge that samples Valid=1. RES_* are valid in the same cycle.
- ALL_READ is combinational from RD_COUNT.

## Configuration
- COST_PARITY_EN defined:
  - Each entry stores an extra even-parity bit computed at load.
  - On every SERVE read, the stored parity is checked.
  - A mismatch sets PERR, which stays set until CLR or reset. Cost still outputs the stored data.
- Not defined: no parity storage or check, and PERR is constant 0.

## Test plan
- Load with table[i] = i mod 128 (i = 0..63), then drive W=3, J=5 → Cost=29 at the following negedge; W=7, J=7 → Cost=63.
- Full JAM scan pattern (W 0..7, J 0..7, one step per negedge) → RD_COUNT reaches 64 and ALL_READ=1. Then reread (0,0) → RD_COUNT stays 64.
- Pulse Valid with MinCost=10'd200, MatchCount=4'd3 in SERVE → DONE=1, RES_MIN=200, RES_CNT=3. A later Valid with other values leaves RES_* unchanged.
- Assert RST low after 20 load beats, release, then do a full 64-beat load of 7'd9 → every read returns 9. LD_READY drops after beat 64.
- Drive CLR and LD_VALID in the same cycle during SERVE → state goes to LOAD, addr=0, RD_COUNT=0. The LD_VALID beat is not written.
- With COST_PARITY_EN defined, force-flip one stored data bit of table[10] and then read (1,2) → PERR=1, and it stays 1 until CLR. Without the macro → PERR stays 0.
